// File: rtl/dog_phys_sched.sv
// Frame sequencer that walks enabled dogs through the physics ops on a shared datapath.
// Optional saturating drop counter is built when DOG_SCHED_OVERRUN_CNT_EN is defined.
module dog_phys_sched #(
    parameter int N      = 4,
    parameter int STAGES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] dog_en,
    input  logic       req_ready,
    output logic       req_valid,
    output logic [1:0] dog_idx,
    output logic [1:0] op,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic [7:0] overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_OP = 2'(STAGES - 1);

    state_t     state_reg, state_next;
    logic [3:0] mask_reg, mask_next;
    logic [1:0] dog_idx_reg, dog_idx_next;
    logic [1:0] op_reg, op_next;
    logic       req_valid_reg;
    logic       busy_reg;
    logic       frame_done_reg;
    logic       overrun_reg, overrun_next;

    logic [3:0] en_masked;
    logic [3:0] above_mask;
    logic [2:0] first_sel;
    logic [2:0] next_sel;
    logic       handshake;

    // Bit 2 is the found flag, bits 1:0 the index of the lowest set bit.
    function automatic logic [2:0] lowest_set(input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_masks
            if (gi < N) begin : g_live
                assign en_masked[gi] = dog_en[gi];
            end else begin : g_dead
                assign en_masked[gi] = 1'b0;
            end
            // Candidates strictly above the dog currently being served.
            assign above_mask[gi] = mask_reg[gi] & (3'(gi) > {1'b0, dog_idx_reg});
        end
    endgenerate

    assign first_sel = lowest_set(en_masked);
    assign next_sel  = lowest_set(above_mask);
    assign handshake = req_valid_reg & req_ready;

    always_comb begin
        state_next   = state_reg;
        mask_next    = mask_reg;
        dog_idx_next = dog_idx_reg;
        op_next      = op_reg;
        overrun_next = frame_tick && (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (frame_tick) begin
                    mask_next = en_masked;
                    if (first_sel[2]) begin
                        state_next   = RUN;
                        dog_idx_next = first_sel[1:0];
                        op_next      = 2'd0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (op_reg == LAST_OP) begin
                        op_next = 2'd0;
                        if (next_sel[2]) begin
                            dog_idx_next = next_sel[1:0];
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        op_next = op_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mask_reg       <= 4'd0;
            dog_idx_reg    <= 2'd0;
            op_reg         <= 2'd0;
            req_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mask_reg       <= mask_next;
            dog_idx_reg    <= dog_idx_next;
            op_reg         <= op_next;
            req_valid_reg  <= (state_next == RUN);
            busy_reg       <= (state_next != IDLE);
            frame_done_reg <= (state_next == DONE);
            overrun_reg    <= overrun_next;
        end
    end

`ifdef DOG_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_cnt_reg <= 8'd0;
        end else if (overrun_next && (overrun_cnt_reg != 8'hFF)) begin
            overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_reg;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign req_valid  = req_valid_reg;
    assign dog_idx    = dog_idx_reg;
    assign op         = op_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule
